bus_sequencer: RTL
==================

// Module: bus_sequencer
// PURPOSE
//  Sequences 1801VM1 core bus cycles (read, write, read-modify-write) between the
//  microcode control word and the external memory/IO bus. It latches address and
//  data from the datapath, runs the rply handshake and captures read data. A
//  no-reply timeout raises a bus error so microcode can trap through vector 004.
//  It sits between the datapath dba/dbo/dbi nets and the board bus.
// PARAMETERS
//  TIMEOUT   15   ce-qualified cycles to wait for bus_rply before bus error (1..255)
//  CNT_W     8    width of timeout counter; must hold TIMEOUT
// PORTS
//  clk        in   1   system clock
//  reset_n    in   1   asynchronous active-low reset
//  ce         in   1   clock enable; no state changes when 0
//  req_rd     in   1   start read cycle (sampled in IDLE/RMW_HOLD)
//  req_wr     in   1   start write cycle
//  req_rmw    in   1   start read cycle, keep address for a following write
//  req_byte   in   1   byte access (1) / word access (0)
//  req_addr   in   16  cycle address (datapath dba)
//  req_wdata  in   16  write data (datapath dbo)
//  bus_addr   out  16  latched bus address
//  bus_rd     out  1   read strobe, held until rply or timeout
//  bus_wr     out  1   write strobe, held until rply or timeout
//  bus_byte   out  1   byte-cycle qualifier
//  bus_dout   out  16  write data; byte writes replicate [7:0] into both halves
//  bus_rply   in   1   slave reply, sampled on ce
//  bus_din    in   16  read data, valid with bus_rply
//  din        out  16  captured read data (datapath dbi)
//  din_active out  1   one ce-cycle pulse: din newly valid
//  done       out  1   one ce-cycle pulse: cycle completed with rply
//  busy       out  1   1 in RD_WAIT/WR_WAIT
//  bus_err    out  1   one ce-cycle pulse: timeout (or odd address, see CONFIGURATION)
//  err_addr   out  16  address of last failed cycle
// BEHAVIOUR
//  - Reset (async): state IDLE; all outputs 0 (bus_addr, bus_dout, din, err_addr = 0).
//    Reset mid-cycle drops bus_rd/bus_wr immediately; no done/bus_err is issued.
//  - Every register updates only on posedge clk with ce=1; pulses stay high until the
//    next ce cycle.
//  - States: IDLE, RD_WAIT, WR_WAIT, RMW_HOLD.
//  - IDLE: priority req_rmw > req_rd > req_wr when more than one is set. On accept,
//    latch addr/byte/wdata, load counter=TIMEOUT, and go to RD_WAIT or WR_WAIT.
//    The strobe is registered and visible in the accept+1 cycle.
//  - RD_WAIT: rply=1 -> din<=bus_din, din_active=1, done=1, drop bus_rd, then go to
//    RMW_HOLD (rmw) or IDLE. rply=0 -> counter decrements. Counter==0 with rply=0 ->
//    bus_err=1, err_addr<=bus_addr, go to IDLE.
//  - WR_WAIT: same rule with bus_wr. No din capture on completion.
//  - Boundary: if rply arrives in the cycle the counter reaches 0, rply wins (no error).
//  - Boundary: a rply seen in IDLE/RMW_HOLD is ignored.
//  - RMW_HOLD: bus_addr and bus_byte are retained and no strobe is driven. There is no
//    timeout. req_wr -> WR_WAIT on the held address; req_addr is ignored; wdata is
//    latched. req_rd/req_rmw abandon the hold and start the new read as from IDLE.
//  - Requests arriving in RD_WAIT/WR_WAIT are ignored. Microcode waits on done/bus_err.
//  - din holds its value until the next read completes. A read that times out leaves
//    din unchanged.
// CONFIGURATION
//  BUS_ODDADDR_TRAP_EN defined: an accepted word request with addr[0]=1 runs no bus
//    cycle. Next cycle: bus_err=1, err_addr=addr, stay in IDLE.
//  Undefined: addr[0] is ignored for word cycles and passed to bus_addr unchanged.
// STRUCTURE
//  - Shared include bus.h: state encodings, TIMEOUT default, TRAP_BUS vector (004)
//    used by microcode on bus_err.
//  - One sub-module, bus_watchdog: load/decrement/zero-flag counter, CNT_W wide,
//    ce-qualified.
// TESTING
//  1. req_rd addr=0o001000, rply after 3 cycles, din=0o123456 -> bus_rd 3 cycles;
//     din=0o123456; din_active/done 1 pulse.
//  2. req_wr byte, wdata=0x00A5 -> bus_dout=0xA5A5, bus_byte=1, done on rply.
//  3. req_rd with no rply, TIMEOUT=15 -> bus_err after 16 cycles of bus_rd;
//     err_addr=addr; done never asserted.
//  4. req_rmw addr=0o177560 + rply, then req_wr with req_addr=0 -> write to
//     0o177560; two done pulses.
//  5. reset_n low during WR_WAIT -> bus_wr=0 immediately; IDLE; no pulses after
//     release. Toggle ce=0 mid-wait -> counter and state frozen.
//  6. BUS_ODDADDR_TRAP_EN: word req_rd addr=0o001001 -> no bus_rd; bus_err next cycle.

Source files
------------

// File: rtl/bus_sequencer_pkg.sv
// Shared definitions for the 1801VM1 bus sequencer: state encodings, timeout
// default, the bus-error trap vector and the write-data formatting helper.
package bus_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_WAIT  = 2'd1,
    ST_WR_WAIT  = 2'd2,
    ST_RMW_HOLD = 2'd3
  } bus_state_t;

  localparam int unsigned TIMEOUT_DEF = 15;

  // Microcode traps through this vector when bus_err pulses.
  localparam logic [15:0] TRAP_BUS = 16'o000004;

  // Byte writes drive the low byte on both halves so either lane can take it.
  function automatic logic [15:0] fmt_wdata(input logic is_byte, input logic [15:0] data);
    return is_byte ? {data[7:0], data[7:0]} : data;
  endfunction

endpackage

// File: rtl/bus_sequencer_watchdog.sv
// No-reply watchdog for the bus sequencer: loadable down-counter with a zero
// flag. Load wins over decrement; the count never wraps below zero.
module bus_watchdog #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ce,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (ce) begin
      if (load)
        r_count <= load_val;
      else if (dec && !zero)
        r_count <= r_count - 1'b1;
    end
  end

  assign zero = (r_count == '0);

endmodule

// File: rtl/bus_sequencer.sv
// 1801VM1 bus cycle sequencer (read / write / read-modify-write with rply timeout).
// Optional feature macro: BUS_ODDADDR_TRAP_EN traps odd-address word requests.
module bus_sequencer
  import bus_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  parameter int          CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce,
  input  logic        req_rd,
  input  logic        req_wr,
  input  logic        req_rmw,
  input  logic        req_byte,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic [15:0] bus_addr,
  output logic        bus_rd,
  output logic        bus_wr,
  output logic        bus_byte,
  output logic [15:0] bus_dout,
  input  logic        bus_rply,
  input  logic [15:0] bus_din,
  output logic [15:0] din,
  output logic        din_active,
  output logic        done,
  output logic        busy,
  output logic        bus_err,
  output logic [15:0] err_addr
);

  bus_state_t  r_state;
  bus_state_t  w_state_nxt;

  logic [15:0] r_addr;
  logic        r_byte;
  logic [15:0] r_dout;
  logic        r_rmw;
  logic [15:0] r_din;
  logic        r_din_active;
  logic        r_done;
  logic        r_bus_err;
  logic [15:0] r_err_addr;

  logic        w_accept;     // new cycle latched from req_addr
  logic        w_accept_rmw;
  logic        w_hold_wr;    // write on the address held after an RMW read
  logic        w_complete;
  logic        w_rd_complete;
  logic        w_timeout;
  logic        w_trap;
  logic        w_wd_dec;
  logic        w_wd_zero;
  logic        w_odd;

`ifdef BUS_ODDADDR_TRAP_EN
  assign w_odd = !req_byte && req_addr[0];
`else
  assign w_odd = 1'b0;
`endif

  bus_watchdog #(.CNT_W(CNT_W)) u_watchdog (
    .clk      (clk),
    .reset_n  (reset_n),
    .ce       (ce),
    .load     (w_accept || w_hold_wr),
    .dec      (w_wd_dec),
    .load_val (CNT_W'(TIMEOUT)),
    .zero     (w_wd_zero)
  );

  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt   = r_state;
    w_accept      = 1'b0;
    w_accept_rmw  = 1'b0;
    w_hold_wr     = 1'b0;
    w_complete    = 1'b0;
    w_rd_complete = 1'b0;
    w_timeout     = 1'b0;
    w_trap        = 1'b0;
    w_wd_dec      = 1'b0;

    unique case (r_state)
      ST_IDLE, ST_RMW_HOLD: begin
        if (req_rmw || req_rd || (req_wr && r_state == ST_IDLE)) begin
          if (w_odd) begin
            w_trap      = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_accept     = 1'b1;
            w_accept_rmw = req_rmw;
            w_state_nxt  = (req_rmw || req_rd) ? ST_RD_WAIT : ST_WR_WAIT;
          end
        end else if (req_wr) begin
          w_hold_wr   = 1'b1;
          w_state_nxt = ST_WR_WAIT;
        end
      end
      ST_RD_WAIT, ST_WR_WAIT: begin
        // rply wins over an expiring counter in the same cycle.
        if (bus_rply) begin
          w_complete    = 1'b1;
          w_rd_complete = (r_state == ST_RD_WAIT);
          w_state_nxt   = (r_state == ST_RD_WAIT && r_rmw) ? ST_RMW_HOLD : ST_IDLE;
        end else if (w_wd_zero) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_wd_dec = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_byte       <= 1'b0;
      r_dout       <= '0;
      r_rmw        <= 1'b0;
      r_din        <= '0;
      r_din_active <= 1'b0;
      r_done       <= 1'b0;
      r_bus_err    <= 1'b0;
      r_err_addr   <= '0;
    end else if (ce) begin
      r_state      <= w_state_nxt;
      r_done       <= w_complete;
      r_din_active <= w_rd_complete;
      r_bus_err    <= w_timeout || w_trap;

      if (w_accept) begin
        r_addr <= req_addr;
        r_byte <= req_byte;
        r_dout <= fmt_wdata(req_byte, req_wdata);
        r_rmw  <= w_accept_rmw;
      end
      if (w_hold_wr)
        r_dout <= fmt_wdata(r_byte, req_wdata);
      if (w_rd_complete)
        r_din <= bus_din;
      if (w_timeout)
        r_err_addr <= r_addr;
      else if (w_trap)
        r_err_addr <= req_addr;
    end
  end

  // Strobes follow the registered state, so reset drops them asynchronously.
  assign bus_rd     = (r_state == ST_RD_WAIT);
  assign bus_wr     = (r_state == ST_WR_WAIT);
  assign busy       = bus_rd || bus_wr;
  assign bus_addr   = r_addr;
  assign bus_byte   = r_byte;
  assign bus_dout   = r_dout;
  assign din        = r_din;
  assign din_active = r_din_active;
  assign done       = r_done;
  assign bus_err    = r_bus_err;
  assign err_addr   = r_err_addr;

endmodule
